// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, frame candidate kinds and
// the key-code width helper.
package keypad_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } kp_state_e;

    typedef enum logic [1:0] {
        CAND_NONE   = 2'd0,
        CAND_SINGLE = 2'd1,
        CAND_MULTI  = 2'd2
    } cand_kind_e;

    function automatic int code_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Compares each frame candidate against the previous one and reports when a
// candidate has been seen DEBOUNCE_FRAMES frames in a row.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_end,
    input  cand_kind_e       cand_kind,
    input  logic [KEY_W-1:0] cand_code,
    output logic             stable_vld,
    output cand_kind_e       stable_kind,
    output logic [KEY_W-1:0] stable_code
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    cand_kind_e       prev_kind_q, prev_kind_d;
    logic [KEY_W-1:0] prev_code_q, prev_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             same;

    always_comb begin
        same        = (cand_kind == prev_kind_q) &&
                      ((cand_kind != CAND_SINGLE) || (cand_code == prev_code_q));
        prev_kind_d = prev_kind_q;
        prev_code_d = prev_code_q;
        cnt_d       = cnt_q;
        if (frame_end) begin
            prev_kind_d = cand_kind;
            prev_code_d = cand_code;
            if (!same)
                cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_W'(DEBOUNCE_FRAMES))
                cnt_d = cnt_q + CNT_W'(1);
        end
        stable_vld  = frame_end && (cnt_d == CNT_W'(DEBOUNCE_FRAMES));
        stable_kind = cand_kind;
        stable_code = cand_code;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_kind_q <= CAND_NONE;
            prev_code_q <= '0;
            cnt_q       <= '0;
        end else begin
            prev_kind_q <= prev_kind_d;
            prev_code_q <= prev_code_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: column drive, per-frame candidate collection,
// press/release FSM and a single-entry event register with overrun flag.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int KEY_W           = code_w(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_release,
    output logic             key_held,
    output logic             overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic [ROWS-1:0]  row_s1_q, row_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cand_kind_e       acc_kind_q, acc_kind_d, merge_kind;
    logic [KEY_W-1:0] acc_code_q, acc_code_d, merge_code, cand_code;
    logic             sample, frame_end;

    logic             stable_vld;
    cand_kind_e       stable_kind;
    logic [KEY_W-1:0] stable_code;

    kp_state_e        state_q;
    logic [KEY_W-1:0] latched_q;
    logic             ev_fire, ev_rel;
    logic [KEY_W-1:0] ev_code;

    assign col = COLS'(1) << idx_q;

    always_comb begin
        sample    = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_end = sample && (idx_q == IDX_W'(COLS - 1));
        div_d     = div_q + DIV_W'(1);
        idx_d     = idx_q;
        if (sample) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(COLS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Fold this column's sample into the running frame candidate; the result
    // at the last column is the frame's candidate.
    always_comb begin
        merge_kind = acc_kind_q;
        merge_code = acc_code_q;
        if (sample) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_s2_q[r]) begin
                    if (merge_kind == CAND_NONE) begin
                        merge_kind = CAND_SINGLE;
                        merge_code = KEY_W'(r * COLS) + KEY_W'(idx_q);
                    end else begin
                        merge_kind = CAND_MULTI;
                    end
                end
            end
        end
        cand_code  = (merge_kind == CAND_SINGLE) ? merge_code : '0;
        acc_kind_d = frame_end ? CAND_NONE : merge_kind;
        acc_code_d = frame_end ? '0 : merge_code;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1_q   <= '0;
            row_s2_q   <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            acc_kind_q <= CAND_NONE;
            acc_code_q <= '0;
        end else begin
            row_s1_q   <= row;
            row_s2_q   <= row_s1_q;
            div_q      <= div_d;
            idx_q      <= idx_d;
            acc_kind_q <= acc_kind_d;
            acc_code_q <= acc_code_d;
        end
    end

    keypad_debounce #(
        .KEY_W          (KEY_W),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .frame_end  (frame_end),
        .cand_kind  (merge_kind),
        .cand_code  (cand_code),
        .stable_vld (stable_vld),
        .stable_kind(stable_kind),
        .stable_code(stable_code)
    );

    always_comb begin
        ev_fire = 1'b0;
        ev_rel  = 1'b0;
        ev_code = latched_q;
        if (stable_vld) begin
            if (state_q == ST_IDLE && stable_kind == CAND_SINGLE) begin
                ev_fire = 1'b1;
                ev_code = stable_code;
            end else if (state_q == ST_PRESSED && stable_kind == CAND_NONE) begin
                ev_fire = 1'b1;
                ev_rel  = 1'b1;
            end
        end
    end

    // FSM advances even when its event is dropped by a full register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            latched_q   <= '0;
            key_held    <= 1'b0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (ev_fire) begin
                if (state_q == ST_IDLE) begin
                    state_q   <= ST_PRESSED;
                    latched_q <= stable_code;
                    key_held  <= 1'b1;
                end else begin
                    state_q  <= ST_IDLE;
                    key_held <= 1'b0;
                end
            end
            if (ev_fire && key_valid && !key_ready) begin
                overrun <= 1'b1;
            end else if (ev_fire) begin
                key_code    <= ev_code;
                key_release <= ev_rel;
                key_valid   <= 1'b1;
            end else if (key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: frame-level model of key events plus literal
// expectations for latency, codes and overrun.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        key_release;
    logic        key_held;
    logic        overrun;
    logic [15:0] keymask = '0;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scan_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_release(key_release),
        .key_held   (key_held),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // A pressed key (r,c) shorts column c onto row r.
    always_comb begin
        for (int r = 0; r < 4; r++)
            row[r] = |(keymask[r*4 +: 4] & col);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // -1 = no key, -2 = several keys, otherwise the key code
    function automatic int cand_of(input logic [15:0] m);
        if ($countones(m) == 0) return -1;
        if ($countones(m) > 1) return -2;
        for (int i = 0; i < 16; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    // Model: one step per clock; frames are 16 cycles counted from reset release.
    int mcyc, run, prev_cand, lcode, m_code, cand, fcode;
    bit held, m_valid, m_rel, m_ovr, fire, frel;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcyc = 0; run = 0; prev_cand = -1; lcode = 0; held = 0;
            m_valid = 0; m_rel = 0; m_code = 0; m_ovr = 0;
        end else begin
            fire = 0; frel = 0; fcode = 0; m_ovr = 0;
            if (mcyc % 16 == 15) begin
                cand = cand_of(keymask);
                run = (cand == prev_cand) ? ((run < 3) ? run + 1 : 3) : 1;
                prev_cand = cand;
                if (run == 3) begin
                    if (!held && cand >= 0) begin
                        fire = 1; fcode = cand; lcode = cand; held = 1;
                    end else if (held && cand == -1) begin
                        fire = 1; frel = 1; fcode = lcode; held = 0;
                    end
                end
            end
            if (fire && m_valid && !key_ready) m_ovr = 1;
            else if (fire) begin m_valid = 1; m_code = fcode; m_rel = frel; end
            else if (key_ready) m_valid = 0;
            mcyc++;
        end
    end

    always @(negedge clk) begin
        check("col", int'(col), 1 << ((mcyc / 4) % 4));
        check("key_valid", int'(key_valid), int'(m_valid));
        check("key_code", int'(key_code), m_code);
        check("key_release", int'(key_release), int'(m_rel));
        check("key_held", int'(key_held), int'(held));
        check("overrun", int'(overrun), int'(m_ovr));
    end

    int ev_code[$], ev_rel[$], ev_cyc[$];
    int n_ovr = 0;

    always @(negedge clk) begin
        if (key_valid && key_ready) begin
            ev_code.push_back(int'(key_code));
            ev_rel.push_back(int'(key_release));
            ev_cyc.push_back(mcyc);
        end
        if (overrun) n_ovr++;
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -99;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        check("rst_col", int'(col), 1);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        reset = 1'b0;

        // clean press of (1,2), then release
        keymask = 16'h0040;
        tick(160);
        check("press_count", ev_code.size(), 1);
        check("press_code", qget(ev_code, 0), 6);
        check("press_rel", qget(ev_rel, 0), 0);
        check("press_cycle", qget(ev_cyc, 0), 48);
        check("press_held", int'(key_held), 1);

        keymask = '0;
        tick(160);
        check("rel_count", ev_code.size(), 2);
        check("rel_code", qget(ev_code, 1), 6);
        check("rel_rel", qget(ev_rel, 1), 1);
        check("rel_cycle", qget(ev_cyc, 1), 208);
        check("rel_held", int'(key_held), 0);

        // bouncing key: changes every frame, never stable
        for (int i = 0; i < 8; i++) begin
            keymask = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            tick(16);
        end
        keymask = '0;
        tick(48);
        check("bounce_count", ev_code.size(), 2);
        check("bounce_held", int'(key_held), 0);

        // two keys at once
        keymask = 16'h8001;
        tick(160);
        keymask = '0;
        tick(48);
        check("multi_count", ev_code.size(), 2);

        // consumer stalled: release event dropped with overrun
        key_ready = 1'b0;
        keymask = 16'h8000;
        tick(80);
        keymask = '0;
        tick(80);
        check("stall_valid", int'(key_valid), 1);
        check("stall_code", int'(key_code), 15);
        check("stall_rel", int'(key_release), 0);
        check("stall_ovr", n_ovr, 1);
        key_ready = 1'b1;
        tick(1);
        check("drain_valid", int'(key_valid), 0);
        check("drain_count", ev_code.size(), 3);
        check("drain_code", qget(ev_code, 2), 15);
        tick(48);

        // reset during debounce of (2,1)
        keymask = 16'h0200;
        tick(32);
        reset = 1'b1;
        keymask = '0;
        tick(3);
        reset = 1'b0;
        tick(160);
        check("rstmid_count", ev_code.size(), 3);
        check("rstmid_held", int'(key_held), 0);
        check("total_ovr", n_ovr, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 4, number of matrix rows sensed.
REQ-002 Parameter COLS, default 4, number of matrix columns driven.
REQ-003 Parameter SCAN_DIV, default 4, clock cycles each column is driven; minimum 4.
REQ-004 Parameter DEBOUNCE_FRAMES, default 3, consecutive identical frames required to accept a state; minimum 1.
REQ-005 Derived KEY_W = clog2(ROWS*COLS), minimum 1; key code = row*COLS + col.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 row  input  ROWS  raw row sense lines, active-high, asynchronous to clk.
REQ-009 col  output  COLS  one-hot active-high column drive.
REQ-010 key_code  output  KEY_W  code of the reported event.
REQ-011 key_valid  output  1  event register holds an unaccepted event.
REQ-012 key_ready  input  1  consumer accepts the event on a clk edge with key_valid=1.
REQ-013 key_release  output  1  event type: 0 press, 1 release; valid with key_valid.
REQ-014 key_held  output  1  debounced key currently down (FSM in PRESSED).
REQ-015 overrun  output  1  one-cycle pulse when an event is dropped.

Function
REQ-016 row SHALL pass a 2-flop synchroniser before any use.
REQ-017 Column index SHALL count 0..COLS-1, advancing every SCAN_DIV cycles, wrapping to 0; col = one-hot(index).
REQ-018 Synchronised row SHALL be sampled on the last dwell cycle of each column.
REQ-019 A frame SHALL end at the sample of column COLS-1; frame length COLS*SCAN_DIV cycles.
REQ-020 Frame candidate: NONE if no bits set; single code if exactly one bit set across frame; MULTI if more than one.
REQ-021 Debounce counter SHALL increment when candidate equals previous frame's candidate, else reload to 1; candidate becomes stable when counter reaches DEBOUNCE_FRAMES (saturate).
REQ-022 FSM states IDLE, PRESSED; IDLE->PRESSED on stable single code, latching it and emitting a press event.
REQ-023 PRESSED->IDLE on stable NONE, emitting a release event carrying the latched code.
REQ-024 Stable MULTI, or stable different single code while PRESSED, SHALL be ignored (no event, no transition).
REQ-025 Event SHALL load into key_code/key_release and set key_valid on the clk edge after the frame-end sample.
REQ-026 key_valid SHALL clear on an edge where key_ready=1, unless a new event loads on the same edge (then stays 1 with new content, no overrun).
REQ-027 New event while key_valid=1 and key_ready=0 SHALL be dropped, register unchanged, overrun=1 for one cycle; FSM still transitions.
REQ-028 Event latency after a clean press: DEBOUNCE_FRAMES frame ends after first frame containing it, plus 1 cycle.

Reset
REQ-029 While reset=1: col=one-hot(0), key_code=0, key_valid=0, key_release=0, key_held=0, overrun=0, FSM IDLE, all counters/synchronisers/candidates cleared (previous candidate=NONE).
REQ-030 Reset mid-debounce or mid-frame SHALL discard partial state; no event results from pre-reset activity.

Structure
REQ-031 Package keypad_pkg SHALL hold FSM state enum, candidate-kind encodings (NONE/SINGLE/MULTI) and the code-width function.
REQ-032 Frame compare and debounce counter SHALL be sub-module keypad_debounce; scan, FSM and event register in top.

Verification (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=3, bench models row[r]=col[c] for pressed keys)
REQ-033 Reset held, row=0 -> col=4'b0001, key_valid=0, key_held=0.
REQ-034 Press (1,2) 10 frames, key_ready=1 -> exactly one event key_code=6, key_release=0; key_held=1.
REQ-035 Then release -> one event key_code=6, key_release=1; key_held=0.
REQ-036 Press (1,2) toggling every frame for 8 frames -> no event, key_held stays 0.
REQ-037 Keys (0,0) and (3,3) together 10 frames -> no event.
REQ-038 key_ready=0, press then release (3,3) -> press event code 15 retained, overrun pulses once; then key_ready=1 -> key_valid clears next edge.
REQ-039 Reset asserted after 2 debounced frames of (2,1) then released -> no event; key_held=0.
